address_sequencer: RTL and testbench
====================================

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 50_000_000, meaning the number of clk cycles per auto-scan step (0.5 s at 100 MHz); legal range is 2 or greater.
REQ-002 The module SHALL have parameter AUTO_INC, default 1, meaning the address advances by 1 after each write when set to 1.
REQ-003 Port clk, input, 1 bit: on-board 100 MHz clock; the only clock.
REQ-004 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port step_btn, input, 1 bit: debounced, asynchronous level; each rising edge advances the address.
REQ-006 Port wr_btn, input, 1 bit: debounced, asynchronous level; each rising edge issues one RAM write.
REQ-007 Port load, input, 1 bit: synchronous level; loads load_val into the address.
REQ-008 Port load_val, input, 8 bits: preset address.
REQ-009 Port scan_en, input, 1 bit: synchronous level; enables timed auto-advance.
REQ-010 Port addr, output, 8 bits: registered RAM address.
REQ-011 Port we, output, 1 bit: registered RAM write enable, one cycle wide.
REQ-012 Port at_end, output, 1 bit: registered flag, high when addr is 8'hFF.

Function
REQ-013 step_btn and wr_btn SHALL each pass through a 2-flop synchronizer plus one delay flop; a rising edge is sync2 high and delay low.
REQ-014 A rising edge SHALL be counted once, regardless of how long the input stays high.
REQ-015 The FSM SHALL have states IDLE, WRITE and POST.
- IDLE to WRITE: on a wr_btn edge.
- WRITE to POST: unconditionally; we is 1 for exactly the WRITE cycle.
- POST to IDLE: unconditionally; addr increments here if AUTO_INC is 1.
REQ-016 addr SHALL be held stable during WRITE, so the RAM latches din at the unchanged addr.
REQ-017 The event priority in IDLE SHALL be, highest first: load, wr_btn edge, step_btn edge, scan tick.
- Only the highest-priority event acts in a cycle.
- Lower-priority edges in that cycle are discarded, not queued.
REQ-018 In WRITE and POST, step, load and scan events SHALL be ignored.
REQ-019 The scan timer SHALL count 0 to SCAN_DIV-1 while scan_en is 1.
- At terminal count it issues a one-cycle tick and returns to 0.
- It clears to 0 whenever scan_en is 0.
REQ-020 The address SHALL increment modulo 256, so 8'hFF + 1 gives 8'h00 with no stall or error flag.
REQ-021 at_end SHALL update in the same cycle as addr.
REQ-022 Latency: the input is first sampled high at edge k; the action occurs at edge k+2.
- step: addr changes at edge k+2.
- write: we is high from edge k+2 to edge k+3.
- AUTO_INC increment: addr changes at edge k+4.
REQ-023 load SHALL update addr at the next edge when the FSM is in IDLE.

Reset
REQ-024 While reset_n is 0 at a clk edge, the following SHALL be forced:
- addr = 8'h00, we = 0, at_end = 0.
- FSM in IDLE, scan timer = 0.
- synchronizer and delay flops = 0.
REQ-025 Reset asserted during WRITE SHALL drop we at that same edge, with no increment afterwards.
REQ-026 A button held high through reset release SHALL produce one edge after release.

Verification
REQ-027 Step test: reset, then 3 separate step_btn pulses (each high 5 cycles) -> addr sequence 00, 01, 02, 03, each change 2 cycles after sampling.
REQ-028 Write test: load with load_val = 8'h10, then a wr_btn pulse.
- we is high exactly 1 cycle while addr = 8'h10.
- addr = 8'h11 two cycles later.
- With AUTO_INC = 0, addr stays 8'h10.
REQ-029 Wrap test: load 8'hFE, then 2 steps -> addr FF with at_end = 1, then 00 with at_end = 0.
REQ-030 Scan test: SCAN_DIV = 4, scan_en = 1 for 20 cycles -> addr advances every 4 cycles, 5 increments total; with scan_en = 0, addr is frozen.
REQ-031 Collision test: load, wr_btn edge and step edge in the same cycle -> only the load takes effect, we stays 0, no increment.
REQ-032 Reset-mid-write test: assert reset_n = 0 during WRITE -> we = 0 and addr = 00 at that edge, FSM in IDLE, no later increment.

Source files
------------

// File: rtl/address_sequencer.sv
// Purpose: 8-bit RAM address sequencer driven by step/write buttons, a preset load and a timed auto-scan.
// Latency: a button sampled high at edge k acts at edge k+2; the post-write auto-increment lands at edge k+4.
// Backpressure: none; events that arrive during WRITE/POST, or lose the same-cycle priority, are dropped.
module address_sequencer #(
  parameter int SCAN_DIV = 50_000_000,
  parameter int AUTO_INC = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_btn,
  input  logic       wr_btn,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       scan_en,
  output logic [7:0] addr,
  output logic       we,
  output logic       at_end
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, POST} state_t;

  state_t          state, state_n;
  logic [1:0]      step_sync, wr_sync;
  logic            step_dly, wr_dly;
  logic            step_edge, wr_edge;
  logic [CW-1:0]   scan_cnt;
  logic            scan_tick;
  logic [7:0]      addr_n;

  // Bring the asynchronous buttons into the clk domain and keep a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_sync <= 2'b00;
      wr_sync   <= 2'b00;
      step_dly  <= 1'b0;
      wr_dly    <= 1'b0;
    end else begin
      step_sync <= {step_sync[0], step_btn};
      wr_sync   <= {wr_sync[0], wr_btn};
      step_dly  <= step_sync[1];
      wr_dly    <= wr_sync[1];
    end
  end

  // A held button yields a single one-cycle edge pulse.
  assign step_edge = step_sync[1] & ~step_dly;
  assign wr_edge   = wr_sync[1] & ~wr_dly;

  // Free-running scan divider, parked at zero whenever auto-scan is off.
  always_ff @(posedge clk) begin
    if (!reset_n || !scan_en) begin
      scan_cnt <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign scan_tick = scan_en && (scan_cnt == CW'(SCAN_DIV - 1));

  // Next-state and next-address decode; in IDLE only the highest-priority event acts.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    case (state)
      IDLE: begin
        if (load) begin
          addr_n = load_val;
        end else if (wr_edge) begin
          state_n = WRITE;
        end else if (step_edge) begin
          addr_n = addr + 8'd1;
        end else if (scan_tick) begin
          addr_n = addr + 8'd1;
        end
      end
      WRITE: begin
        // addr is held so the RAM captures data at the unchanged address.
        state_n = POST;
      end
      POST: begin
        state_n = IDLE;
        if (AUTO_INC == 1) begin
          addr_n = addr + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs; at_end is derived from the next address so it moves with addr.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr   <= 8'h00;
      at_end <= 1'b0;
      we     <= 1'b0;
    end else begin
      addr   <= addr_n;
      at_end <= (addr_n == 8'hFF);
      we     <= (state_n == WRITE);
    end
  end

endmodule

// File: tb/tb_address_sequencer.sv
// Purpose: scoreboard bench for address_sequencer with AUTO_INC=1 and AUTO_INC=0 instances side by side.
// Latency: expectations carry the exact cycle at which each output change must appear.
// Backpressure: not applicable; every output change pops one expectation.
module tb_address_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       we;
    logic       at_end;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       step_btn;
  logic       wr_btn;
  logic       load;
  logic [7:0] load_val;
  logic       scan_en;
  logic [7:0] addr0, addr1;
  logic       we0, we1, ae0, ae1;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_on = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] m [2];
  logic [9:0] prev [2];

  address_sequencer #(.SCAN_DIV(4), .AUTO_INC(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .step_btn(step_btn), .wr_btn(wr_btn),
    .load(load), .load_val(load_val), .scan_en(scan_en),
    .addr(addr0), .we(we0), .at_end(ae0)
  );

  address_sequencer #(.SCAN_DIV(4), .AUTO_INC(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .step_btn(step_btn), .wr_btn(wr_btn),
    .load(load), .load_val(load_val), .scan_en(scan_en),
    .addr(addr1), .we(we1), .at_end(ae1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of {addr,we,at_end} on either instance pops and checks one expectation.
  always @(negedge clk) begin
    logic [9:0] cur [2];
    exp_t e;
    bit   have;
    cur[0] = {addr0, we0, ae0};
    cur[1] = {addr1, we1, ae1};
    for (int d = 0; d < 2; d++) begin
      if (mon_on && (cur[d] !== prev[d])) begin
        tests++;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1'b1;
        end
        if (!have) begin
          fails++;
          $display("FAIL mon%0d unexpected change at cyc=%0d: addr=%h we=%b at_end=%b, required no change",
                   d, cyc, cur[d][9:2], cur[d][1], cur[d][0]);
        end else if (e.cyc != cyc || cur[d] !== {e.addr, e.we, e.at_end}) begin
          fails++;
          $display("FAIL mon%0d got cyc=%0d addr=%h we=%b at_end=%b, required cyc=%0d addr=%h we=%b at_end=%b",
                   d, cyc, cur[d][9:2], cur[d][1], cur[d][0], e.cyc, e.addr, e.we, e.at_end);
        end
      end
      prev[d] = cur[d];
    end
  end

  function automatic void push(int d, int c, logic [7:0] a, logic w);
    exp_t e;
    e.cyc    = c;
    e.addr   = a;
    e.we     = w;
    e.at_end = (a == 8'hFF);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [9:0] act, logic [9:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  // Step button pulse high for 5 cycles; one increment two cycles after the first sample.
  task automatic do_step();
    int n;
    n = cyc;
    step_btn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m[d] = m[d] + 8'd1;
      push(d, n + 3, m[d], 1'b0);
    end
    repeat (5) tick();
    step_btn = 1'b0;
    repeat (5) tick();
  endtask

  // One-cycle load pulse; address takes load_val at the next edge.
  task automatic do_load(logic [7:0] v);
    int n;
    n = cyc;
    load     = 1'b1;
    load_val = v;
    for (int d = 0; d < 2; d++) begin
      if (m[d] != v) push(d, n + 1, v, 1'b0);
      m[d] = v;
    end
    tick();
    load = 1'b0;
    repeat (2) tick();
  endtask

  // Write pulse: we high for one cycle at the held address, then auto-increment on instance 0 only.
  task automatic do_write();
    int n;
    n = cyc;
    wr_btn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      push(d, n + 3, m[d], 1'b1);
      push(d, n + 4, m[d], 1'b0);
    end
    m[0] = m[0] + 8'd1;
    push(0, n + 5, m[0], 1'b0);
    repeat (3) tick();
    wr_btn = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    step_btn = 1'b0;
    wr_btn   = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    scan_en  = 1'b0;
    m[0]     = 8'h00;
    m[1]     = 8'h00;

    // Reset state.
    repeat (3) tick();
    chk("reset_dut0", {addr0, we0, ae0}, 10'h000);
    chk("reset_dut1", {addr1, we1, ae1}, 10'h000);
    reset_n = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();

    // Three separate steps: 01, 02, 03.
    repeat (3) do_step();

    // Load 10 then write: we at 10; instance 0 moves to 11, instance 1 stays 10.
    do_load(8'h10);
    do_write();
    chk("write_hold_dut1", {2'b00, addr1}, 10'h010);

    // Wrap: FE -> FF (at_end) -> 00.
    do_load(8'hFE);
    do_step();
    do_step();

    // Auto-scan for 20 cycles: five increments, then frozen.
    n = cyc;
    scan_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      for (int d = 0; d < 2; d++) begin
        m[d] = m[d] + 8'd1;
        push(d, n + 4 * i, m[d], 1'b0);
      end
    end
    repeat (20) tick();
    scan_en = 1'b0;
    repeat (10) tick();
    chk("scan_frozen_dut0", {2'b00, addr0}, 10'h005);

    // Collision: load, write edge and step edge in the same cycle -> only the load acts.
    n = cyc;
    wr_btn   = 1'b1;
    step_btn = 1'b1;
    repeat (2) tick();
    load     = 1'b1;
    load_val = 8'h40;
    for (int d = 0; d < 2; d++) begin
      push(d, n + 3, 8'h40, 1'b0);
      m[d] = 8'h40;
    end
    tick();
    load = 1'b0;
    repeat (6) tick();
    wr_btn   = 1'b0;
    step_btn = 1'b0;
    repeat (4) tick();

    // Reset during WRITE: we drops and addr clears at that edge, no later increment.
    n = cyc;
    wr_btn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      push(d, n + 3, m[d], 1'b1);
      push(d, n + 4, 8'h00, 1'b0);
      m[d] = 8'h00;
    end
    repeat (3) tick();
    reset_n = 1'b0;
    wr_btn  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (8) tick();

    // Button held high through reset release gives exactly one step afterwards.
    n = cyc;
    step_btn = 1'b1;
    reset_n  = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m[d] = m[d] + 8'd1;
      push(d, n + 5, m[d], 1'b0);
    end
    repeat (8) tick();
    step_btn = 1'b0;
    repeat (4) tick();

    // Every expected change must have been observed.
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL drain_dut0 pending=%0d required 0", q0.size());
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL drain_dut1 pending=%0d required 0", q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
